multicycle_control: RTL and testbench

Multicycle successor to the single-cycle control decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the same datapath control bus per state. It adds IR/PC write strobes, a request/acknowledge handshake to a variable-latency memory, an illegal-opcode trap and a sticky halt. It sits between the instruction register and the multicycle datapath in the CPU top level.

---
 rtl/cpu_ctrl_pkg.sv | 64 ++++++
 rtl/alu_op_decode.sv | 35 +++
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU control path: opcodes, functs, ALU op codes, FSM states and the
// control bundle driven onto the datapath.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLTZ  = 6'b000110;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_PASS = 4'b1000;

    typedef enum logic [3:0] {
        StIf    = 4'd0,
        StId    = 4'd1,
        StExR   = 4'd2,
        StExI   = 4'd3,
        StExAd  = 4'd4,
        StMemRd = 4'd5,
        StMemWr = 4'd6,
        StWbAlu = 4'd7,
        StWbLd  = 4'd8,
        StExBr  = 4'd9,
        StExJ   = 4'd10,
        StHalt  = 4'd11
    } state_e;

    typedef struct packed {
        logic [3:0] aluop;
        logic       regwrite;
        logic       alusrca;
        logic       alusrcb;
        logic       regdst;
        logic       extsel;
        logic       datasrc;
        logic       mwr;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       irwrite;
        logic       mem_req;
        logic       illegal;
        logic       halted;
    } ctl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational op/funct to ALU opcode mapping, plus a legality flag for the trap logic.
module alu_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] aluop,
    output logic       legal
);

    always_comb begin
        aluop = ALU_PASS;
        legal = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL:  aluop = ALU_SLL;
                    FN_ADD:  aluop = ALU_ADD;
                    FN_SUB:  aluop = ALU_SUB;
                    FN_AND:  aluop = ALU_AND;
                    FN_OR:   aluop = ALU_OR;
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDIU, OP_LW, OP_SW:    aluop = ALU_ADD;
            OP_ANDI:                   aluop = ALU_AND;
            OP_ORI:                    aluop = ALU_OR;
            OP_SLTI:                   aluop = ALU_SLT;
            OP_BEQ, OP_BNE, OP_BLTZ:   aluop = ALU_SUB;
            OP_J, OP_HALT:             aluop = ALU_PASS;
            default:                   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences IF/ID/EX/MEM/WB and drives the datapath control bus per state.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W       = 4,
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned STATE_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               sign,
    input  logic               mem_ack,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               Regwrite,
    output logic               ALUsrcA,
    output logic               ALUsrcB,
    output logic               RegDst,
    output logic               ExtSel,
    output logic               datasrc,
    output logic               mWR,
    output logic [1:0]         pcsrc,
    output logic               PCwrite,
    output logic               IRwrite,
    output logic               mem_req,
    output logic               illegal,
    output logic               halted,
    output logic [STATE_W-1:0] state
);

    state_e     state_q, state_d;
    ctl_t       c;
    logic [3:0] dec_aluop;
    logic       dec_legal;
    logic       ack;
    logic       taken;

    assign ack = (MEM_HANDSHAKE != 0) ? mem_ack : 1'b1;

    alu_op_decode u_alu_op_decode (
        .op    (op),
        .funct (funct),
        .aluop (dec_aluop),
        .legal (dec_legal)
    );

    always_comb begin
        case (op)
            OP_BEQ:  taken = zero;
            OP_BNE:  taken = ~zero;
            OP_BLTZ: taken = sign;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIf;
        else        state_q <= state_d;
    end

    always_comb begin
        c       = '0;
        state_d = state_q;
        case (state_q)
            StIf: begin
                c.mem_req = 1'b1;
                c.irwrite = ack;
                c.pcwrite = ack;
                if (ack) state_d = StId;
            end
            StId: begin
                if (!dec_legal) begin
                    // PC already advanced in IF, so returning to IF skips the bad instruction.
                    c.illegal = 1'b1;
                    state_d   = StIf;
                end else begin
                    case (op)
                        OP_RTYPE:                          state_d = StExR;
                        OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: state_d = StExI;
                        OP_LW, OP_SW:                      state_d = StExAd;
                        OP_BEQ, OP_BNE, OP_BLTZ:           state_d = StExBr;
                        OP_J:                              state_d = StExJ;
                        OP_HALT:                           state_d = StHalt;
                        default:                           state_d = StIf;
                    endcase
                end
            end
            StExR: begin
                c.aluop   = dec_aluop;
                c.alusrca = (funct == FN_SLL);
                state_d   = StWbAlu;
            end
            StExI: begin
                c.aluop   = dec_aluop;
                c.alusrcb = 1'b1;
                c.extsel  = (op == OP_ADDIU) || (op == OP_SLTI);
                state_d   = StWbAlu;
            end
            StExAd: begin
                c.aluop   = ALU_ADD;
                c.alusrcb = 1'b1;
                c.extsel  = 1'b1;
                state_d   = (op == OP_LW) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                c.mem_req = 1'b1;
                if (ack) state_d = StWbLd;
            end
            StMemWr: begin
                c.mem_req = 1'b1;
                c.mwr     = 1'b1;
                if (ack) state_d = StIf;
            end
            StWbAlu: begin
                c.regwrite = 1'b1;
                c.regdst   = (op == OP_RTYPE);
                state_d    = StIf;
            end
            StWbLd: begin
                c.regwrite = 1'b1;
                c.datasrc  = 1'b1;
                state_d    = StIf;
            end
            StExBr: begin
                c.aluop   = ALU_SUB;
                c.extsel  = 1'b1;
                c.pcsrc   = taken ? 2'd1 : 2'd0;
                c.pcwrite = taken;
                state_d   = StIf;
            end
            StExJ: begin
                c.pcsrc   = 2'd2;
                c.pcwrite = 1'b1;
                state_d   = StIf;
            end
            StHalt: c.halted = 1'b1;
            default: state_d = StIf;
        endcase
        // Reset forces every output low, including the IF memory request.
        if (!rst_n) c = '0;
    end

    assign ALUop    = ALUOP_W'(c.aluop);
    assign Regwrite = c.regwrite;
    assign ALUsrcA  = c.alusrca;
    assign ALUsrcB  = c.alusrcb;
    assign RegDst   = c.regdst;
    assign ExtSel   = c.extsel;
    assign datasrc  = c.datasrc;
    assign mWR      = c.mwr;
    assign pcsrc    = c.pcsrc;
    assign PCwrite  = c.pcwrite;
    assign IRwrite  = c.irwrite;
    assign mem_req  = c.mem_req;
    assign illegal  = c.illegal;
    assign halted   = c.halted;
    assign state    = rst_n ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: one handshaking instance for the instruction walk-throughs, one with
// MEM_HANDSHAKE=0 and mem_ack tied low for the single-cycle memory store case.
module tb_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst_n0;
    logic [5:0] op, funct, op0;
    logic       zero, sign, mem_ack;

    logic [3:0] ALUop, ALUop0;
    logic       Regwrite, ALUsrcA, ALUsrcB, RegDst, ExtSel, datasrc, mWR;
    logic       Regwrite0, ALUsrcA0, ALUsrcB0, RegDst0, ExtSel0, datasrc0, mWR0;
    logic [1:0] pcsrc, pcsrc0;
    logic       PCwrite, IRwrite, mem_req, illegal, halted;
    logic       PCwrite0, IRwrite0, mem_req0, illegal0, halted0;
    logic [3:0] state, state0;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.ALUOP_W(4), .MEM_HANDSHAKE(1), .STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .sign(sign),
        .mem_ack(mem_ack), .ALUop(ALUop), .Regwrite(Regwrite), .ALUsrcA(ALUsrcA),
        .ALUsrcB(ALUsrcB), .RegDst(RegDst), .ExtSel(ExtSel), .datasrc(datasrc), .mWR(mWR),
        .pcsrc(pcsrc), .PCwrite(PCwrite), .IRwrite(IRwrite), .mem_req(mem_req),
        .illegal(illegal), .halted(halted), .state(state)
    );

    multicycle_control #(.ALUOP_W(4), .MEM_HANDSHAKE(0), .STATE_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n0), .op(op0), .funct(6'b000000), .zero(1'b0), .sign(1'b0),
        .mem_ack(1'b0), .ALUop(ALUop0), .Regwrite(Regwrite0), .ALUsrcA(ALUsrcA0),
        .ALUsrcB(ALUsrcB0), .RegDst(RegDst0), .ExtSel(ExtSel0), .datasrc(datasrc0),
        .mWR(mWR0), .pcsrc(pcsrc0), .PCwrite(PCwrite0), .IRwrite(IRwrite0),
        .mem_req(mem_req0), .illegal(illegal0), .halted(halted0), .state(state0)
    );

    logic [17:0] ctl, ctl0;
    assign ctl  = {ALUop, Regwrite, ALUsrcA, ALUsrcB, RegDst, ExtSel, datasrc, mWR, pcsrc,
                   PCwrite, IRwrite, mem_req, illegal, halted};
    assign ctl0 = {ALUop0, Regwrite0, ALUsrcA0, ALUsrcB0, RegDst0, ExtSel0, datasrc0, mWR0,
                   pcsrc0, PCwrite0, IRwrite0, mem_req0, illegal0, halted0};

    localparam int C_HALT = 1, C_ILL = 2, C_REQ = 4, C_IRW = 8, C_PCW = 16;
    localparam int C_PCS1 = 32, C_PCS2 = 64, C_MWR = 128, C_DSRC = 256, C_EXT = 512;
    localparam int C_RDST = 1024, C_SRCB = 2048, C_SRCA = 4096, C_REGW = 8192;
    localparam int C_FETCH = C_REQ | C_IRW | C_PCW;

    function automatic int alu(input int a);
        return a << 14;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_dut(input string tag, input int st, input int c);
        chk({tag, " state"}, {28'd0, state}, st);
        chk({tag, " ctl"}, {14'd0, ctl}, c);
    endtask

    task automatic expect_dut0(input string tag, input int st, input int c);
        chk({tag, " state"}, {28'd0, state0}, st);
        chk({tag, " ctl"}, {14'd0, ctl0}, c);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive the instruction fields and flags, then check the combinational outputs.
    task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic a, input logic z,
                       input logic s, input string tag, input int st, input int c);
        nxt();
        op = o; funct = f; mem_ack = a; zero = z; sign = s;
        #1;
        expect_dut(tag, st, c);
    endtask

    initial begin
        rst_n = 1'b0; rst_n0 = 1'b0;
        op = 6'b0; funct = 6'b0; zero = 1'b0; sign = 1'b0; mem_ack = 1'b0;
        op0 = 6'b101011;
        nxt();
        nxt();
        expect_dut("reset", 0, 0);
        expect_dut0("reset0", 0, 0);
        rst_n = 1'b1;
        #1;
        expect_dut("idle_if", 0, C_REQ);

        // add: IF, ID, EX_R, WB_ALU
        cyc(6'h00, 6'h20, 1, 0, 0, "add_if", 0, C_FETCH);
        cyc(6'h00, 6'h20, 0, 0, 0, "add_id", 1, 0);
        cyc(6'h00, 6'h20, 1, 0, 0, "add_ex", 2, alu(4));
        cyc(6'h00, 6'h20, 0, 0, 0, "add_wb", 7, C_REGW | C_RDST);
        // sll selects the shamt operand
        cyc(6'h00, 6'h00, 1, 0, 0, "sll_if", 0, C_FETCH);
        cyc(6'h00, 6'h00, 0, 0, 0, "sll_id", 1, 0);
        cyc(6'h00, 6'h00, 0, 0, 0, "sll_ex", 2, alu(7) | C_SRCA);
        cyc(6'h00, 6'h00, 0, 0, 0, "sll_wb", 7, C_REGW | C_RDST);
        // ori: zero-extended immediate, rt destination
        cyc(6'h0D, 6'h00, 1, 0, 0, "ori_if", 0, C_FETCH);
        cyc(6'h0D, 6'h00, 0, 0, 0, "ori_id", 1, 0);
        cyc(6'h0D, 6'h00, 0, 0, 0, "ori_ex", 3, alu(1) | C_SRCB);
        cyc(6'h0D, 6'h00, 0, 0, 0, "ori_wb", 7, C_REGW);
        // slti: sign-extended
        cyc(6'h0A, 6'h00, 1, 0, 0, "slti_if", 0, C_FETCH);
        cyc(6'h0A, 6'h00, 0, 0, 0, "slti_id", 1, 0);
        cyc(6'h0A, 6'h00, 0, 0, 0, "slti_ex", 3, alu(6) | C_SRCB | C_EXT);
        cyc(6'h0A, 6'h00, 0, 0, 0, "slti_wb", 7, C_REGW);
        // lw with three wait cycles in MEM_RD: 8 cycles total
        cyc(6'h23, 6'h00, 1, 0, 0, "lw_if", 0, C_FETCH);
        cyc(6'h23, 6'h00, 0, 0, 0, "lw_id", 1, 0);
        cyc(6'h23, 6'h00, 0, 0, 0, "lw_ex", 4, alu(4) | C_SRCB | C_EXT);
        cyc(6'h23, 6'h00, 0, 0, 0, "lw_mem1", 5, C_REQ);
        cyc(6'h23, 6'h00, 0, 0, 0, "lw_mem2", 5, C_REQ);
        cyc(6'h23, 6'h00, 0, 0, 0, "lw_mem3", 5, C_REQ);
        cyc(6'h23, 6'h00, 1, 0, 0, "lw_mem4", 5, C_REQ);
        cyc(6'h23, 6'h00, 0, 0, 0, "lw_wb", 8, C_REGW | C_DSRC);
        // sw with one wait cycle
        cyc(6'h2B, 6'h00, 1, 0, 0, "sw_if", 0, C_FETCH);
        cyc(6'h2B, 6'h00, 0, 0, 0, "sw_id", 1, 0);
        cyc(6'h2B, 6'h00, 0, 0, 0, "sw_ex", 4, alu(4) | C_SRCB | C_EXT);
        cyc(6'h2B, 6'h00, 0, 0, 0, "sw_mem1", 6, C_REQ | C_MWR);
        cyc(6'h2B, 6'h00, 1, 0, 0, "sw_mem2", 6, C_REQ | C_MWR);
        cyc(6'h2B, 6'h00, 0, 0, 0, "sw_done", 0, C_REQ);
        // beq taken
        cyc(6'h04, 6'h00, 1, 1, 0, "beq_if", 0, C_FETCH);
        cyc(6'h04, 6'h00, 0, 1, 0, "beq_id", 1, 0);
        cyc(6'h04, 6'h00, 0, 1, 0, "beq_ex", 9, alu(5) | C_EXT | C_PCS1 | C_PCW);
        // bne not taken, then taken
        cyc(6'h05, 6'h00, 1, 1, 0, "bne_if", 0, C_FETCH);
        cyc(6'h05, 6'h00, 0, 1, 0, "bne_id", 1, 0);
        cyc(6'h05, 6'h00, 0, 1, 0, "bne_nt", 9, alu(5) | C_EXT);
        cyc(6'h05, 6'h00, 1, 0, 0, "bne2_if", 0, C_FETCH);
        cyc(6'h05, 6'h00, 0, 0, 0, "bne2_id", 1, 0);
        cyc(6'h05, 6'h00, 0, 0, 0, "bne_t", 9, alu(5) | C_EXT | C_PCS1 | C_PCW);
        // bltz taken on sign, not on zero
        cyc(6'h06, 6'h00, 1, 0, 1, "bltz_if", 0, C_FETCH);
        cyc(6'h06, 6'h00, 0, 0, 1, "bltz_id", 1, 0);
        cyc(6'h06, 6'h00, 0, 1, 1, "bltz_t", 9, alu(5) | C_EXT | C_PCS1 | C_PCW);
        // j
        cyc(6'h02, 6'h00, 1, 0, 0, "j_if", 0, C_FETCH);
        cyc(6'h02, 6'h00, 0, 0, 0, "j_id", 1, 0);
        cyc(6'h02, 6'h00, 0, 0, 0, "j_ex", 10, C_PCS2 | C_PCW);
        // illegal opcode: one-cycle trap in ID, back to IF
        cyc(6'h10, 6'h00, 1, 0, 0, "ill_if", 0, C_FETCH);
        cyc(6'h10, 6'h00, 0, 0, 0, "ill_id", 1, C_ILL);
        cyc(6'h10, 6'h00, 0, 0, 0, "ill_next", 0, C_REQ);
        // illegal R-type funct
        cyc(6'h00, 6'h01, 1, 0, 0, "illf_if", 0, C_FETCH);
        cyc(6'h00, 6'h01, 0, 0, 0, "illf_id", 1, C_ILL);
        // halt: HALT in cycle 3, ack pulses ignored
        cyc(6'h3F, 6'h00, 1, 0, 0, "halt_if", 0, C_FETCH);
        cyc(6'h3F, 6'h00, 0, 0, 0, "halt_id", 1, 0);
        cyc(6'h3F, 6'h00, 0, 0, 0, "halt_1", 11, C_HALT);
        cyc(6'h3F, 6'h00, 1, 0, 0, "halt_ack", 11, C_HALT);
        cyc(6'h3F, 6'h00, 0, 0, 0, "halt_2", 11, C_HALT);
        nxt();
        rst_n = 1'b0;
        #1;
        expect_dut("halt_rst", 0, 0);
        nxt();
        rst_n = 1'b1;
        #1;
        expect_dut("after_rst", 0, C_REQ);

        // single-cycle memory instance: sw in 4 cycles, mWR for exactly one
        rst_n0 = 1'b1;
        #1;
        expect_dut0("sw0_if", 0, C_FETCH);
        nxt();
        expect_dut0("sw0_id", 1, 0);
        nxt();
        expect_dut0("sw0_ex", 4, alu(4) | C_SRCB | C_EXT);
        nxt();
        expect_dut0("sw0_mem", 6, C_REQ | C_MWR);
        nxt();
        expect_dut0("sw0_next", 0, C_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
